branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
//
// PURPOSE
//   Pipelined branch/jump resolution functional unit. It sits between the branch reservation
//   station and the CDB/ROB writeback arbiter. It resolves conditional branches, JAL and JALR,
//   computes the actual next PC and the link value, and detects mispredictions against the
//   fetch-stage prediction. Two register stages, valid/ready handshakes on both sides, global
//   flush, saturating mispredict counter.
//
// PARAMETERS
//   XLEN   32  datapath / PC width
//   TAG_W  4   ROB tag width
//   CNT_W  16  mispredict counter width
//
// PORTS
//   clock            in   1      rising-edge clock
//   reset            in   1      asynchronous, active-low reset
//   flush            in   1      squash all in-flight ops (sync, 1 cycle)
//   in_valid         in   1      issue request
//   in_ready         out  1      unit can accept this cycle
//   in_kind          in   2      00 cond branch, 01 JAL, 10 JALR, 11 illegal
//   in_func          in   3      funct3 for cond branch (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   in_rs1           in   XLEN   operand 1 (JALR base)
//   in_rs2           in   XLEN   operand 2
//   in_offset        in   XLEN   sign-extended immediate
//   in_pc            in   XLEN   PC of the instruction
//   in_pred_taken    in   1      fetch predicted taken
//   in_pred_target   in   XLEN   fetch predicted target
//   in_tag           in   TAG_W  ROB tag
//   out_valid        out  1      result available
//   out_ready        in   1      consumer accepts result
//   out_tag          out  TAG_W  ROB tag of result
//   out_taken        out  1      actual taken
//   out_next_pc      out  XLEN   actual next PC (target if taken, else PC+4)
//   out_link         out  XLEN   PC+4 (rd writeback for JAL/JALR)
//   out_mispredict   out  1      redirect required
//   out_misaligned   out  1      taken and target[1:0] != 0
//   out_illegal      out  1      in_kind==11 or reserved func (010/011)
//   mispredict_count out  CNT_W  saturating count of retired mispredicts
//
// BEHAVIOUR
//   - Reset (reset==0, async): S1/S2 valid=0; all out_* data = 0; mispredict_count = 0;
//     in_ready = 1 after release.
//   - Stage S1 captures the input on in_valid && in_ready. Resolution logic is
//     combinational S1 -> S2. Outputs are driven from S2 registers.
//   - Latency: accepted at edge N -> out_valid = 1 after edge N+1. Throughput is 1/cycle.
//   - Advance rules:
//     - S2 loads when !S2.valid || out_ready.
//     - S1 -> S2 moves under the same condition.
//     - in_ready = !S1.valid || (!S2.valid || out_ready). Full throughput with no
//       combinational in_ready <- out_ready bubble beyond that term.
//   - Backpressure: while out_valid && !out_ready, every out_* signal holds stable.
//   - Cond branch:
//     - BEQ: rs1 == rs2. BNE: !=.
//     - BLT / BGE: signed compare. BLTU / BGEU: unsigned compare.
//     - Reserved func: taken = 0, out_illegal = 1.
//   - Target:
//     - Branch / JAL: pc + offset.
//     - JALR: (rs1 + offset) & ~1.
//     - All adds are modulo 2^XLEN (wrap, no overflow flag).
//   - JAL / JALR: taken = 1 always.
//   - Illegal kind: taken = 0, next_pc = pc+4, out_illegal = 1, mispredict per the rule below.
//   - out_link = pc + 4, modulo 2^XLEN, for every kind.
//   - out_mispredict = (taken != pred_taken) || (taken && target != pred_target).
//     Not-taken ops ignore pred_target.
//   - out_misaligned = taken && target[1:0] != 2'b00. It does not alter out_mispredict.
//   - flush:
//     - Clears S1.valid and S2.valid at the next edge, overriding any advance.
//     - in_valid in the flush cycle is dropped.
//     - in_ready stays 1 in that cycle (the dropped request counts as consumed).
//     - A handshake at out in the flush cycle still completes and counts.
//   - mispredict_count:
//     - +1 on out_valid && out_ready && out_mispredict.
//     - Saturates at all-ones.
//     - Cleared only by reset; flush does not clear it.
//   - Reset asserted mid-operation: in-flight ops are lost, with no partial output.
//
// TESTING
//   1. BEQ rs1=rs2=0x5, pc=0x100, off=0x20, pred_taken=1, pred_target=0x120
//      -> 2 cycles later: taken=1, next_pc=0x120, link=0x104, mispredict=0.
//   2. rs1=0xFFFFFFFF, rs2=0x1: BLT -> taken=1; BLTU -> taken=0.
//      BLTU with pred_taken=1 -> mispredict=1, next_pc=pc+4.
//   3. JALR rs1=0x1003, off=0x4 -> next_pc=0x1006, misaligned=1.
//      pc=0xFFFFFFFC -> link=0x00000000 (wrap).
//   4. Back-to-back 4 ops with out_ready low for 3 cycles
//      -> in_ready drops once S1 and S2 are full; outputs are stable while stalled;
//      order and tags are preserved; no loss or duplication.
//   5. flush while both stages are full and in_valid=1 -> next cycle out_valid=0,
//      no stale result emitted, counter unchanged.
//   6. CNT_W=2, five mispredicting handshakes -> count 1,2,3,3,3.
//      reset low mid-stream -> out_valid=0 and count=0 immediately.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit
//   Two-stage pipelined branch/jump resolution unit between the branch
//   reservation station and the CDB/ROB writeback arbiter. Resolves
//   conditional branches, JAL and JALR, produces the actual next PC and the
//   link value, flags mispredictions against the fetch prediction, and keeps
//   a saturating count of retired mispredicts.
//
//   S1 registers the raw issue request; resolution is combinational from S1
//   into the S2 registers, which drive every out_* port.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   flush                 squash both stages at the next edge
//   in_valid / in_ready   issue handshake
//   in_kind, in_func      op kind (branch/JAL/JALR/illegal) and branch funct3
//   in_rs1, in_rs2        operands (rs1 is the JALR base)
//   in_offset, in_pc      sign-extended immediate and instruction PC
//   in_pred_taken/target  fetch-stage prediction
//   in_tag                ROB tag
//   out_valid / out_ready result handshake
//   out_tag, out_taken, out_next_pc, out_link
//   out_mispredict, out_misaligned, out_illegal
//   mispredict_count      saturating count of retired mispredicts
// ----------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,

  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_kind,
  input  logic [2:0]       in_func,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_offset,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             in_pred_taken,
  input  logic [XLEN-1:0]  in_pred_target,
  input  logic [TAG_W-1:0] in_tag,

  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_next_pc,
  output logic [XLEN-1:0]  out_link,
  output logic             out_mispredict,
  output logic             out_misaligned,
  output logic             out_illegal,
  output logic [CNT_W-1:0] mispredict_count
);

  typedef enum logic [1:0] {
    KIND_BR   = 2'b00,
    KIND_JAL  = 2'b01,
    KIND_JALR = 2'b10,
    KIND_ILL  = 2'b11
  } kind_e;

  typedef enum logic [2:0] {
    F_BEQ  = 3'b000,
    F_BNE  = 3'b001,
    F_RSV2 = 3'b010,
    F_RSV3 = 3'b011,
    F_BLT  = 3'b100,
    F_BGE  = 3'b101,
    F_BLTU = 3'b110,
    F_BGEU = 3'b111
  } func_e;

  typedef struct packed {
    kind_e            kind;
    func_e            func;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [XLEN-1:0]  offset;
    logic [XLEN-1:0]  pc;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             taken;
    logic [XLEN-1:0]  next_pc;
    logic [XLEN-1:0]  link;
    logic             mispredict;
    logic             misaligned;
    logic             illegal;
  } s2_t;

  logic             s1_valid_q, s1_valid_d;
  s1_t              s1_q, s1_d;
  logic             s2_valid_q, s2_valid_d;
  s2_t              s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s2_adv;
  logic             out_fire;
  s2_t              res;

  // Resolution datapath
  logic [XLEN-1:0]  link;
  logic [XLEN-1:0]  br_target;
  logic [XLEN-1:0]  jalr_target;
  logic [XLEN-1:0]  target;
  logic             taken;
  logic             illegal;
  logic             eq;
  logic             lt_s;
  logic             lt_u;

  always_comb begin
    link        = s1_q.pc + XLEN'(4);
    br_target   = s1_q.pc + s1_q.offset;
    // JALR clears bit 0 of the computed address.
    jalr_target = (s1_q.rs1 + s1_q.offset) & {{(XLEN-1){1'b1}}, 1'b0};
    eq          = (s1_q.rs1 == s1_q.rs2);
    lt_s        = ($signed(s1_q.rs1) < $signed(s1_q.rs2));
    lt_u        = (s1_q.rs1 < s1_q.rs2);

    taken   = 1'b0;
    illegal = 1'b0;
    target  = br_target;

    unique case (s1_q.kind)
      KIND_BR: begin
        target = br_target;
        unique case (s1_q.func)
          F_BEQ:  taken = eq;
          F_BNE:  taken = !eq;
          F_BLT:  taken = lt_s;
          F_BGE:  taken = !lt_s;
          F_BLTU: taken = lt_u;
          F_BGEU: taken = !lt_u;
          F_RSV2,
          F_RSV3: illegal = 1'b1;
        endcase
      end
      KIND_JAL: begin
        target = br_target;
        taken  = 1'b1;
      end
      KIND_JALR: begin
        target = jalr_target;
        taken  = 1'b1;
      end
      KIND_ILL: begin
        illegal = 1'b1;
      end
    endcase

    res            = '0;
    res.tag        = s1_q.tag;
    res.taken      = taken;
    res.next_pc    = taken ? target : link;
    res.link       = link;
    // Predicted target only matters when the op is actually taken.
    res.mispredict = (taken != s1_q.pred_taken) ||
                     (taken && (target != s1_q.pred_target));
    res.misaligned = taken && (target[1:0] != 2'b00);
    res.illegal    = illegal;
  end

  // Pipeline control
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    // A request presented during flush is consumed and discarded.
    in_ready = flush || !s1_valid_q || s2_adv;
    out_fire = s2_valid_q && out_ready;

    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    cnt_d      = cnt_q;

    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid && !flush) begin
        s1_d.kind        = kind_e'(in_kind);
        s1_d.func        = func_e'(in_func);
        s1_d.rs1         = in_rs1;
        s1_d.rs2         = in_rs2;
        s1_d.offset      = in_offset;
        s1_d.pc          = in_pc;
        s1_d.pred_taken  = in_pred_taken;
        s1_d.pred_target = in_pred_target;
        s1_d.tag         = in_tag;
      end
    end

    // S2 data only changes on advance, so outputs hold under backpressure.
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q && !flush) begin
        s2_d = res;
      end
    end

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end

    // The output handshake in a flush cycle still completes and is counted.
    if (out_fire && s2_q.mispredict && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      s2_q       <= s2_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid        = s2_valid_q;
  assign out_tag          = s2_q.tag;
  assign out_taken        = s2_q.taken;
  assign out_next_pc      = s2_q.next_pc;
  assign out_link         = s2_q.link;
  assign out_mispredict   = s2_q.mispredict;
  assign out_misaligned   = s2_q.misaligned;
  assign out_illegal      = s2_q.illegal;
  assign mispredict_count = cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit, built with a 2-bit mispredict
// counter so saturation is reachable in a handful of ops.
module tb_branch_resolve_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned CNT_W = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_kind;
  logic [2:0]       in_func;
  logic [XLEN-1:0]  in_rs1, in_rs2, in_offset, in_pc, in_pred_target;
  logic             in_pred_taken;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [TAG_W-1:0] out_tag;
  logic             out_taken;
  logic [XLEN-1:0]  out_next_pc, out_link;
  logic             out_mispredict, out_misaligned, out_illegal;
  logic [CNT_W-1:0] mispredict_count;

  branch_resolve_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_func(in_func),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_offset(in_offset), .in_pc(in_pc),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_taken(out_taken), .out_next_pc(out_next_pc), .out_link(out_link),
    .out_mispredict(out_mispredict), .out_misaligned(out_misaligned),
    .out_illegal(out_illegal), .mispredict_count(mispredict_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_op(input logic [1:0] k, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] off, input logic [31:0] pc,
                          input logic pt, input logic [31:0] ptg,
                          input logic [3:0] tg);
    in_valid       = 1'b1;
    in_kind        = k;
    in_func        = f;
    in_rs1         = a;
    in_rs2         = b;
    in_offset      = off;
    in_pc          = pc;
    in_pred_taken  = pt;
    in_pred_target = ptg;
    in_tag         = tg;
  endtask

  typedef struct {
    logic [1:0]  kind;
    logic [2:0]  func;
    logic [31:0] rs1, rs2, off, pc;
    logic        pt;
    logic [31:0] ptg;
    logic        taken;
    logic [31:0] next_pc, link;
    logic        mis, misal, ill;
  } vec_t;

  vec_t vecs[13];
  logic [1:0] exp_cnt;

  initial begin
    //           kind   func    rs1           rs2     off           pc            pt    ptg           tk    next          link          mis   mal   ill
    vecs[0]  = '{2'b00, 3'b000, 32'h5,        32'h5,  32'h20,       32'h100,      1'b1, 32'h120,      1'b1, 32'h120,      32'h104,      1'b0, 1'b0, 1'b0};
    vecs[1]  = '{2'b00, 3'b100, 32'hFFFFFFFF, 32'h1,  32'h40,       32'h200,      1'b1, 32'h240,      1'b1, 32'h240,      32'h204,      1'b0, 1'b0, 1'b0};
    vecs[2]  = '{2'b00, 3'b110, 32'hFFFFFFFF, 32'h1,  32'h40,       32'h200,      1'b1, 32'h240,      1'b0, 32'h204,      32'h204,      1'b1, 1'b0, 1'b0};
    vecs[3]  = '{2'b10, 3'b000, 32'h1003,     32'h0,  32'h4,        32'h300,      1'b1, 32'h1006,     1'b1, 32'h1006,     32'h304,      1'b0, 1'b1, 1'b0};
    vecs[4]  = '{2'b01, 3'b000, 32'h0,        32'h0,  32'h8,        32'hFFFFFFFC, 1'b1, 32'h4,        1'b1, 32'h4,        32'h0,        1'b0, 1'b0, 1'b0};
    vecs[5]  = '{2'b00, 3'b101, 32'hFFFFFFFF, 32'h1,  32'h10,       32'h400,      1'b0, 32'h0,        1'b0, 32'h404,      32'h404,      1'b0, 1'b0, 1'b0};
    vecs[6]  = '{2'b00, 3'b111, 32'hFFFFFFFF, 32'h1,  32'h10,       32'h400,      1'b0, 32'h0,        1'b1, 32'h410,      32'h404,      1'b1, 1'b0, 1'b0};
    vecs[7]  = '{2'b00, 3'b001, 32'h5,        32'h6,  32'hFFFFFFF8, 32'h500,      1'b1, 32'h4F8,      1'b1, 32'h4F8,      32'h504,      1'b0, 1'b0, 1'b0};
    vecs[8]  = '{2'b00, 3'b010, 32'h5,        32'h5,  32'h20,       32'h600,      1'b0, 32'h0,        1'b0, 32'h604,      32'h604,      1'b0, 1'b0, 1'b1};
    vecs[9]  = '{2'b11, 3'b000, 32'h0,        32'h0,  32'h0,        32'h700,      1'b1, 32'h0,        1'b0, 32'h704,      32'h704,      1'b1, 1'b0, 1'b1};
    vecs[10] = '{2'b00, 3'b000, 32'h7,        32'h7,  32'h10,       32'h800,      1'b1, 32'h900,      1'b1, 32'h810,      32'h804,      1'b1, 1'b0, 1'b0};
    vecs[11] = '{2'b10, 3'b000, 32'hFFFFFFFF, 32'h0,  32'h2,        32'h900,      1'b0, 32'h0,        1'b1, 32'h0,        32'h904,      1'b1, 1'b0, 1'b0};
    vecs[12] = '{2'b00, 3'b000, 32'h1,        32'h2,  32'h10,       32'hA00,      1'b0, 32'h12345678, 1'b0, 32'hA04,      32'hA04,      1'b0, 1'b0, 1'b0};
  end

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive_op(2'b00, 3'b000, '0, '0, '0, '0, 1'b0, '0, '0);
    in_valid = 1'b0;
    exp_cnt  = '0;

    // Reset state
    #12;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_next_pc", out_next_pc, 32'd0);
    check_eq("rst_link", out_link, 32'd0);
    check_eq("rst_tag", {28'd0, out_tag}, 32'd0);
    check_eq("rst_cnt", {30'd0, mispredict_count}, 32'd0);
    @(negedge clock) reset = 1'b1;
    @(negedge clock);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed single-op vectors
    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      drive_op(vecs[i].kind, vecs[i].func, vecs[i].rs1, vecs[i].rs2, vecs[i].off,
               vecs[i].pc, vecs[i].pt, vecs[i].ptg, 4'(i));
      @(negedge clock);
      in_valid = 1'b0;
      check_eq($sformatf("v%0d_lat", i), {31'd0, out_valid}, 32'd0);
      @(negedge clock);
      check_eq($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check_eq($sformatf("v%0d_tag", i), {28'd0, out_tag}, 32'(i));
      check_eq($sformatf("v%0d_taken", i), {31'd0, out_taken}, {31'd0, vecs[i].taken});
      check_eq($sformatf("v%0d_next_pc", i), out_next_pc, vecs[i].next_pc);
      check_eq($sformatf("v%0d_link", i), out_link, vecs[i].link);
      check_eq($sformatf("v%0d_mis", i), {31'd0, out_mispredict}, {31'd0, vecs[i].mis});
      check_eq($sformatf("v%0d_misal", i), {31'd0, out_misaligned}, {31'd0, vecs[i].misal});
      check_eq($sformatf("v%0d_ill", i), {31'd0, out_illegal}, {31'd0, vecs[i].ill});
      if (vecs[i].mis && exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
      @(negedge clock);
      check_eq($sformatf("v%0d_cnt", i), {30'd0, mispredict_count}, {30'd0, exp_cnt});
      check_eq($sformatf("v%0d_drain", i), {31'd0, out_valid}, 32'd0);
    end

    // Back-to-back with output stalled for three cycles
    @(negedge clock);
    out_ready = 1'b0;
    drive_op(2'b01, 3'b000, '0, '0, 32'h40, 32'h1000, 1'b1, 32'h1040, 4'd8);
    check_eq("bp_rdy0", {31'd0, in_ready}, 32'd1);
    @(negedge clock);
    drive_op(2'b01, 3'b000, '0, '0, 32'h40, 32'h1010, 1'b1, 32'h1050, 4'd9);
    check_eq("bp_rdy1", {31'd0, in_ready}, 32'd1);
    @(negedge clock);
    drive_op(2'b01, 3'b000, '0, '0, 32'h40, 32'h1020, 1'b1, 32'h1060, 4'd10);
    check_eq("bp_full_rdy", {31'd0, in_ready}, 32'd0);
    check_eq("bp_c2_tag", {28'd0, out_tag}, 32'd8);
    check_eq("bp_c2_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clock);
    check_eq("bp_hold_tag", {28'd0, out_tag}, 32'd8);
    check_eq("bp_hold_pc", out_next_pc, 32'h1040);
    check_eq("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_rdy", {31'd0, in_ready}, 32'd1);
    @(negedge clock);
    check_eq("bp_o1_tag", {28'd0, out_tag}, 32'd9);
    check_eq("bp_o1_pc", out_next_pc, 32'h1050);
    drive_op(2'b01, 3'b000, '0, '0, 32'h40, 32'h1030, 1'b1, 32'h1070, 4'd11);
    @(negedge clock);
    check_eq("bp_o2_tag", {28'd0, out_tag}, 32'd10);
    check_eq("bp_o2_pc", out_next_pc, 32'h1060);
    in_valid = 1'b0;
    @(negedge clock);
    check_eq("bp_o3_tag", {28'd0, out_tag}, 32'd11);
    check_eq("bp_o3_pc", out_next_pc, 32'h1070);
    check_eq("bp_o3_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clock);
    check_eq("bp_empty", {31'd0, out_valid}, 32'd0);
    check_eq("bp_cnt", {30'd0, mispredict_count}, {30'd0, exp_cnt});

    // Reset asserted with a result waiting
    out_ready = 1'b0;
    drive_op(2'b01, 3'b000, '0, '0, 32'h8, 32'h2000, 1'b0, '0, 4'd5);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    check_eq("mr_pre_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b0;
    #1;
    check_eq("mr_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mr_cnt", {30'd0, mispredict_count}, 32'd0);
    check_eq("mr_next_pc", out_next_pc, 32'd0);
    check_eq("mr_tag", {28'd0, out_tag}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_eq("mr_after_valid", {31'd0, out_valid}, 32'd0);

    // Flush with both stages full; output handshake in the flush cycle counts
    out_ready = 1'b0;
    drive_op(2'b11, 3'b000, '0, '0, '0, 32'h3000, 1'b1, '0, 4'd1);
    @(negedge clock);
    drive_op(2'b00, 3'b110, 32'hFFFFFFFF, 32'h1, 32'h40, 32'h3100, 1'b1, 32'h3140, 4'd2);
    @(negedge clock);
    drive_op(2'b01, 3'b000, '0, '0, 32'h40, 32'h3200, 1'b0, '0, 4'd3);
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    check_eq("fl_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("fl_out_tag", {28'd0, out_tag}, 32'd1);
    check_eq("fl_out_mis", {31'd0, out_mispredict}, 32'd1);
    @(negedge clock);
    flush = 1'b0;
    in_valid = 1'b0;
    check_eq("fl_valid1", {31'd0, out_valid}, 32'd0);
    check_eq("fl_cnt1", {30'd0, mispredict_count}, 32'd1);
    @(negedge clock);
    check_eq("fl_valid2", {31'd0, out_valid}, 32'd0);
    check_eq("fl_cnt2", {30'd0, mispredict_count}, 32'd1);

    // Unit still operates after flush
    drive_op(2'b10, 3'b000, 32'h4000, '0, 32'h10, 32'h3300, 1'b1, 32'h4014, 4'd7);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    check_eq("pf_tag", {28'd0, out_tag}, 32'd7);
    check_eq("pf_next_pc", out_next_pc, 32'h4010);
    check_eq("pf_mis", {31'd0, out_mispredict}, 32'd1);
    @(negedge clock);
    check_eq("pf_cnt", {30'd0, mispredict_count}, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
